// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the 32x64 register file write path.
//   RF_AW / RF_DW / RF_DEPTH : register file geometry
//   arb_state_t              : write arbiter state (IDLE = free arbitration,
//                              LOCK = grant held by one requester for a burst)
//   ring_index()             : (base + step) mod n, used for round-robin scans
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 64;
  localparam int RF_DEPTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int ring_index(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The first asserted request found
// scanning ptr, ptr+1, ... (mod NREQ) wins.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  IW    index with highest priority this cycle (must be < NREQ)
//   gnt  out NREQ  one-hot grant, all zero when no request is set
//   idx  out IW    binary index of the winner (0 when no request is set)
// ---------------------------------------------------------------------------
module rr_pick
  import rf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic          any_req;
  logic [IW-1:0] cand;

  // Scan from the far end of the ring back towards ptr so that the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'(ring_index(int'(ptr), k, NREQ));
      if (req[cand]) begin
        idx     = cand;
        any_req = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt[gi] = any_req && (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Round-robin arbiter sharing the single RF write port among NREQ requesters,
// each with a valid/ready handshake. A requester may hold the grant for up to
// MAX_BURST back-to-back writes by keeping req_burst high. The RF write port
// is driven from registers: an accepted write appears one edge later and is
// held for one cycle (longer only while rf_stall freezes the stage).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid[NREQ]       requester i has a write pending
//   req_burst[NREQ]       requester i asks to keep the grant after this write
//   req_rw/req_offset     per-requester index/offset, slice i = [i*AW +: AW]
//   req_din               per-requester data, slice i = [i*DW +: DW]
//   req_ready[NREQ]       one-hot or zero, write i accepted this cycle
//   rf_stall              RF port unavailable, freeze everything
//   load/Rw/offset/din    RF write port
//   grant_id              requester that owns the current load pulse
// ---------------------------------------------------------------------------
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = RF_DW,
  parameter int AW        = RF_AW,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_burst,
  input  logic [NREQ*AW-1:0] req_rw,
  input  logic [NREQ*AW-1:0] req_offset,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]   req_ready,
  input  logic              rf_stall,
  output logic              load,
  output logic [AW-1:0]     Rw,
  output logic [AW-1:0]     offset,
  output logic [DW-1:0]     din,
  output logic [2:0]        grant_id
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next;

  logic          load_reg, load_next;
  logic [AW-1:0] rw_reg, rw_next;
  logic [AW-1:0] offset_reg, offset_next;
  logic [DW-1:0] din_reg, din_next;
  logic [2:0]    grant_id_reg, grant_id_next;

  // Per-requester views of the flattened input buses.
  logic [AW-1:0]   rw_arr     [NREQ];
  logic [AW-1:0]   offset_arr [NREQ];
  logic [DW-1:0]   din_arr    [NREQ];
  logic [NREQ-1:0] owner_hot;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign rw_arr[gi]     = req_rw[gi*AW +: AW];
      assign offset_arr[gi] = req_offset[gi*AW +: AW];
      assign din_arr[gi]    = req_din[gi*DW +: DW];
      assign owner_hot[gi]  = (owner_reg == IW'(gi));
    end
  endgenerate

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  logic [NREQ-1:0] ready_vec;
  logic [IW-1:0]   sel_idx;
  logic            accept;

  // Ready is purely combinational; in LOCK only the owner can be served, so a
  // cycle where the owner has nothing to send grants nobody.
  always_comb begin
    ready_vec = '0;
    if (rst_n && !rf_stall) begin
      if (state_reg == IDLE) begin
        ready_vec = pick_gnt;
      end else begin
        ready_vec = owner_hot & req_valid;
      end
    end
  end

  assign sel_idx   = (state_reg == LOCK) ? owner_reg : pick_idx;
  assign accept    = |(req_valid & ready_vec);
  assign req_ready = ready_vec;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    load_next      = load_reg;
    rw_next        = rw_reg;
    offset_next    = offset_reg;
    din_next       = din_reg;
    grant_id_next  = grant_id_reg;

    // Under stall every register keeps its value, so a pending load stays on
    // the port until the RF can take it.
    if (!rf_stall) begin
      load_next = 1'b0;
      if (accept) begin
        load_next     = 1'b1;
        rw_next       = rw_arr[sel_idx];
        offset_next   = offset_arr[sel_idx];
        din_next      = din_arr[sel_idx];
        grant_id_next = 3'(sel_idx);
      end

      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            ptr_next = IW'(ring_index(int'(pick_idx), 1, NREQ));
            if (req_burst[pick_idx] && (MAX_BURST > 1)) begin
              state_next     = LOCK;
              owner_next     = pick_idx;
              burst_cnt_next = CW'(1);
            end
          end
        end
        LOCK: begin
          if (!req_valid[owner_reg]) begin
            state_next     = IDLE;
            burst_cnt_next = '0;
          end else if (accept) begin
            if (!req_burst[owner_reg] || (int'(burst_cnt_reg) + 1 >= MAX_BURST)) begin
              state_next     = IDLE;
              burst_cnt_next = '0;
            end else begin
              burst_cnt_next = burst_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next     = IDLE;
          burst_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      load_reg      <= 1'b0;
      rw_reg        <= '0;
      offset_reg    <= '0;
      din_reg       <= '0;
      grant_id_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      load_reg      <= load_next;
      rw_reg        <= rw_next;
      offset_reg    <= offset_next;
      din_reg       <= din_next;
      grant_id_reg  <= grant_id_next;
    end
  end

  assign load     = load_reg;
  assign Rw       = rw_reg;
  assign offset   = offset_reg;
  assign din      = din_reg;
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
// Self-checking bench for rf_write_arbiter (NREQ=4, DW=64, AW=5, MAX_BURST=4).
// Each requester is a small model: left[i] writes still to send with fixed
// fields f_*[i]; valid is high while left[i] != 0 and left[i] drops on each
// handshake. Expected writes are queued in grant order and popped whenever
// the DUT shows load.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rf_stall;
  logic [3:0]   req_valid;
  logic [3:0]   req_burst;
  logic [19:0]  req_rw;
  logic [19:0]  req_offset;
  logic [255:0] req_din;
  logic [3:0]   req_ready;
  logic         load;
  logic [4:0]   Rw;
  logic [4:0]   offset;
  logic [63:0]  din;
  logic [2:0]   grant_id;

  int          left    [4];
  logic [4:0]  f_rw    [4];
  logic [4:0]  f_off   [4];
  logic [63:0] f_din   [4];
  logic        f_burst [4];

  typedef struct packed {
    logic [2:0]  gid;
    logic [4:0]  rw;
    logic [4:0]  off;
    logic [63:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req
      assign req_valid[gi]          = (left[gi] != 0);
      assign req_burst[gi]          = f_burst[gi];
      assign req_rw[gi*5 +: 5]      = f_rw[gi];
      assign req_offset[gi*5 +: 5]  = f_off[gi];
      assign req_din[gi*64 +: 64]   = f_din[gi];
    end
  endgenerate

  rf_write_arbiter #(
    .NREQ      (4),
    .DW        (64),
    .AW        (5),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_burst  (req_burst),
    .req_rw     (req_rw),
    .req_offset (req_offset),
    .req_din    (req_din),
    .req_ready  (req_ready),
    .rf_stall   (rf_stall),
    .load       (load),
    .Rw         (Rw),
    .offset     (offset),
    .din        (din),
    .grant_id   (grant_id)
  );

  function automatic void push_exp(input int id);
    exp_t e;
    e.gid = 3'(id);
    e.rw  = f_rw[id];
    e.off = f_off[id];
    e.d   = f_din[id];
    exp_q.push_back(e);
  endfunction

  // One clock: sample outputs at the falling edge, let the rising edge happen,
  // then retire handshaken writes from the requester model and apply rf_stall.
  task automatic step(input logic stall_after, output logic ld, output logic [2:0] gid,
                      output logic [4:0] rw, output logic [4:0] off,
                      output logic [63:0] d, output logic [3:0] rdy);
    logic [3:0] fires;
    @(negedge clk);
    ld    = load;
    gid   = grant_id;
    rw    = Rw;
    off   = offset;
    d     = din;
    rdy   = req_ready;
    fires = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fires[i] && left[i] > 0) left[i] = left[i] - 1;
    end
    rf_stall = stall_after;
  endtask

  task automatic test_reset();
    logic ld; logic [2:0] gid; logic [4:0] rw, off; logic [63:0] d; logic [3:0] rdy;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      left[i]    = 1;
      f_rw[i]    = 5'(20 + i);
      f_off[i]   = 5'(i);
      f_din[i]   = 64'(500 + i);
      f_burst[i] = 1'b0;
    end
    rst_n    = 1'b0;
    rf_stall = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, ld, gid, rw, off, d, rdy);
      total++;
      if (ld !== 1'b0 || rdy !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold: load=%b ready=%b, want load=0 ready=0000", ld, rdy);
      end
    end
    rst_n = 1'b1;
    step(1'b0, ld, gid, rw, off, d, rdy);
    total++;
    if (rdy !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_ready: ready=%b, want 0001", rdy);
    end
    for (int i = 0; i < 4; i++) push_exp(i);
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      step(1'b0, ld, gid, rw, off, d, rdy);
      if (ld === 1'b1) begin
        e = exp_q.pop_front();
        total++;
        if ({gid, rw, off, d} !== e) begin
          bad++;
          $display("FAIL reset_order: gid=%0d rw=%0d off=%0d din=%0d, want gid=%0d rw=%0d off=%0d din=%0d",
                   gid, rw, off, d, e.gid, e.rw, e.off, e.d);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_timeout: %0d writes missing, want 0", exp_q.size());
    end
    exp_q.delete();
    $display("test_reset: done, checks so far=%0d", total);
  endtask

  task automatic test_round_robin();
    logic ld; logic [2:0] gid; logic [4:0] rw, off; logic [63:0] d; logic [3:0] rdy;
    exp_t e;
    int   gaps;
    bit   started;
    for (int i = 0; i < 4; i++) begin
      left[i]  = (i == 0) ? 2 : 1;
      f_rw[i]  = 5'(i + 1);
      f_off[i] = 5'(3 * i);
      f_din[i] = 64'(150 + i);
    end
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    gaps    = 0;
    started = 1'b0;
    for (int c = 0; c < 15 && exp_q.size() > 0; c++) begin
      step(1'b0, ld, gid, rw, off, d, rdy);
      if (ld === 1'b1) begin
        started = 1'b1;
        e = exp_q.pop_front();
        total++;
        if ({gid, rw, off, d} !== e) begin
          bad++;
          $display("FAIL rr_order: gid=%0d rw=%0d off=%0d din=%0d, want gid=%0d rw=%0d off=%0d din=%0d",
                   gid, rw, off, d, e.gid, e.rw, e.off, e.d);
        end
      end else if (started) begin
        gaps++;
      end
    end
    total++;
    if (exp_q.size() != 0 || gaps != 0) begin
      bad++;
      $display("FAIL rr_throughput: missing=%0d gaps=%0d, want missing=0 gaps=0", exp_q.size(), gaps);
    end
    exp_q.delete();
    step(1'b0, ld, gid, rw, off, d, rdy);
    total++;
    if (ld !== 1'b0) begin
      bad++;
      $display("FAIL rr_idle_after: load=%b, want 0", ld);
    end
    $display("test_round_robin: done, checks so far=%0d", total);
  endtask

  task automatic test_burst();
    logic ld; logic [2:0] gid; logic [4:0] rw, off; logic [63:0] d; logic [3:0] rdy;
    exp_t e;
    for (int i = 0; i < 4; i++) left[i] = 0;
    left[1]    = 5;
    f_burst[1] = 1'b1;
    f_rw[1]    = 5'd9;
    f_din[1]   = 64'h1111;
    left[2]    = 1;
    f_rw[2]    = 5'd9;
    f_din[2]   = 64'h2222;
    // MAX_BURST=4 ends the first lock so requester 2 slips in before requester 1 resumes.
    push_exp(1); push_exp(1); push_exp(1); push_exp(1); push_exp(2); push_exp(1);
    for (int c = 0; c < 15 && exp_q.size() > 0; c++) begin
      step(1'b0, ld, gid, rw, off, d, rdy);
      if (ld === 1'b1) begin
        e = exp_q.pop_front();
        total++;
        if ({gid, rw, off, d} !== e) begin
          bad++;
          $display("FAIL burst_order: gid=%0d rw=%0d din=%0h, want gid=%0d rw=%0d din=%0h",
                   gid, rw, d, e.gid, e.rw, e.d);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL burst_timeout: %0d writes missing, want 0", exp_q.size());
    end
    exp_q.delete();
    step(1'b0, ld, gid, rw, off, d, rdy);
    total++;
    if (ld !== 1'b0) begin
      bad++;
      $display("FAIL burst_idle_after: load=%b, want 0", ld);
    end
    f_burst[1] = 1'b0;
    $display("test_burst: done, checks so far=%0d", total);
  endtask

  task automatic test_stall();
    logic ld; logic [2:0] gid; logic [4:0] rw, off; logic [63:0] d; logic [3:0] rdy;
    for (int i = 0; i < 4; i++) left[i] = 0;
    left[0]  = 1; f_rw[0] = 5'd7;  f_off[0] = 5'd4; f_din[0] = 64'hAAAA;
    left[1]  = 1; f_rw[1] = 5'd13; f_off[1] = 5'd2; f_din[1] = 64'hBBBB;
    step(1'b1, ld, gid, rw, off, d, rdy);
    total++;
    if (rdy !== 4'b0001) begin
      bad++;
      $display("FAIL stall_pre_ready: ready=%b, want 0001", rdy);
    end
    for (int c = 0; c < 3; c++) begin
      step((c == 2) ? 1'b0 : 1'b1, ld, gid, rw, off, d, rdy);
      total++;
      if (ld !== 1'b1 || rw !== 5'd7 || off !== 5'd4 || gid !== 3'd0 || rdy !== 4'b0000) begin
        bad++;
        $display("FAIL stall_hold: load=%b rw=%0d off=%0d gid=%0d ready=%b, want 1 7 4 0 0000",
                 ld, rw, off, gid, rdy);
      end
    end
    step(1'b0, ld, gid, rw, off, d, rdy);
    total++;
    if (rdy !== 4'b0010 || rw !== 5'd7) begin
      bad++;
      $display("FAIL stall_release: ready=%b rw=%0d, want ready=0010 rw=7", rdy, rw);
    end
    step(1'b0, ld, gid, rw, off, d, rdy);
    total++;
    if (ld !== 1'b1 || gid !== 3'd1 || rw !== 5'd13 || d !== 64'hBBBB) begin
      bad++;
      $display("FAIL stall_next_grant: load=%b gid=%0d rw=%0d din=%0h, want 1 1 13 bbbb", ld, gid, rw, d);
    end
    step(1'b0, ld, gid, rw, off, d, rdy);
    total++;
    if (ld !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_dup: load=%b, want 0", ld);
    end
    $display("test_stall: done, checks so far=%0d", total);
  endtask

  task automatic test_mid_reset();
    logic ld; logic [2:0] gid; logic [4:0] rw, off; logic [63:0] d; logic [3:0] rdy;
    exp_t e;
    for (int i = 0; i < 4; i++) left[i] = 0;
    left[0] = 1; f_rw[0] = 5'd11; f_off[0] = 5'd1; f_din[0] = 64'h0C0C;
    left[2] = 1; f_rw[2] = 5'd12; f_off[2] = 5'd5; f_din[2] = 64'h0D0D;
    // ptr sits at 2 here, so requester 2 is offered the port; reset lands
    // before the edge that would register its write.
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL midrst_pre_ready: ready=%b, want 0100", req_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_ready_low: ready=%b, want 0000", req_ready);
    end
    @(posedge clk);
    #1;
    step(1'b0, ld, gid, rw, off, d, rdy);
    total++;
    if (ld !== 1'b0 || rw !== 5'd0 || d !== 64'd0) begin
      bad++;
      $display("FAIL midrst_load: load=%b rw=%0d din=%0h, want 0 0 0", ld, rw, d);
    end
    rst_n = 1'b1;
    step(1'b0, ld, gid, rw, off, d, rdy);
    total++;
    if (rdy !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_ptr0: ready=%b, want 0001", rdy);
    end
    push_exp(0); push_exp(2);
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      step(1'b0, ld, gid, rw, off, d, rdy);
      if (ld === 1'b1) begin
        e = exp_q.pop_front();
        total++;
        if ({gid, rw, off, d} !== e) begin
          bad++;
          $display("FAIL midrst_order: gid=%0d rw=%0d din=%0h, want gid=%0d rw=%0d din=%0h",
                   gid, rw, d, e.gid, e.rw, e.d);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_timeout: %0d writes missing, want 0", exp_q.size());
    end
    exp_q.delete();
    $display("test_mid_reset: done, checks so far=%0d", total);
  endtask

  task automatic test_idle_edge();
    logic ld; logic [2:0] gid; logic [4:0] rw, off; logic [63:0] d; logic [3:0] rdy;
    for (int i = 0; i < 4; i++) left[i] = 0;
    for (int k = 0; k < 3; k++) begin
      f_rw[3]  = 5'(16 + k);
      f_off[3] = 5'(k);
      f_din[3] = 64'(256 + k);
      left[3]  = 1;
      step(1'b0, ld, gid, rw, off, d, rdy);
      total++;
      if (rdy !== 4'b1000) begin
        bad++;
        $display("FAIL idle_immediate: ready=%b, want 1000", rdy);
      end
      step(1'b0, ld, gid, rw, off, d, rdy);
      total++;
      if (ld !== 1'b1 || gid !== 3'd3 || rw !== 5'(16 + k) || d !== 64'(256 + k)) begin
        bad++;
        $display("FAIL idle_grant: load=%b gid=%0d rw=%0d din=%0d, want 1 3 %0d %0d",
                 ld, gid, rw, d, 16 + k, 256 + k);
      end
      step(1'b0, ld, gid, rw, off, d, rdy);
      total++;
      if (ld !== 1'b0 || rw !== 5'(16 + k) || d !== 64'(256 + k)) begin
        bad++;
        $display("FAIL idle_hold: load=%b rw=%0d din=%0d, want 0 %0d %0d", ld, rw, d, 16 + k, 256 + k);
      end
    end
    $display("test_idle_edge: done, checks so far=%0d", total);
  endtask

  initial begin
    rst_n    = 1'b0;
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i]    = 0;
      f_rw[i]    = '0;
      f_off[i]   = '0;
      f_din[i]   = '0;
      f_burst[i] = 1'b0;
    end
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_mid_reset();
    test_idle_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
